// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock byte FIFO.
// Imported by sync_fifo and sync_dualport_sram.
package sync_fifo_pkg;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_ADDR_BITS = 4;

   function automatic int fifo_depth(input int a);
      return 1 << a;
   endfunction

endpackage

// File: rtl/sync_dualport_sram.sv
// Simple dual-port SRAM: one write port, one registered read port.
// Read data holds its value when read_en is low.
module sync_dualport_sram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 write_en,
   input  logic [ADDR_BITS-1:0] write_addr,
   input  logic [DATA_BITS-1:0] write_data,
   input  logic                 read_en,
   input  logic [ADDR_BITS-1:0] read_addr,
   output logic [DATA_BITS-1:0] read_data
);

   localparam int DEPTH = fifo_depth(ADDR_BITS);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [DATA_BITS-1:0] read_data_q;

   always_ff @(posedge clk) begin
      if (write_en)
         mem_q[write_addr] <= write_data;
      if (read_en)
         read_data_q <= mem_q[read_addr];
   end

   assign read_data = read_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO around sync_dualport_sram with registered flags/count.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 full,
   output logic [ADDR_BITS:0]   count
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                 overflow,
   output logic                 underflow
`endif
);

   localparam int CW = ADDR_BITS + 1;
   localparam logic [ADDR_BITS:0] DEPTH_C = CW'(fifo_depth(ADDR_BITS));

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic                 empty_q, empty_d;
   logic                 full_q, full_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 wr_acc, rd_acc;

   assign wr_acc = wr_en && !full_q;
   assign rd_acc = rd_en && !empty_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_valid_d = rd_acc;
      if (wr_acc)
         wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (rd_acc)
         rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky: records any rejected request until the next reset.
   assign ovf_d = ovf_q | (wr_en & full_q);
   assign udf_d = udf_q | (rd_en & empty_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`endif

   sync_dualport_sram #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_sram (
      .clk        (clk),
      .write_en   (wr_acc),
      .write_addr (wr_ptr_q),
      .write_data (wr_data),
      .read_en    (rd_acc),
      .read_addr  (rd_ptr_q),
      .read_data  (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DATA_BITS=8, ADDR_BITS=2) against a queue model.
// Define SYNC_FIFO_ERR_EN to also check the sticky error flags.
module tb_sync_fifo;

   localparam int DB    = 8;
   localparam int AB    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [DB-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [DB-1:0] rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [AB:0]   count;
`ifdef SYNC_FIFO_ERR_EN
   logic          overflow;
   logic          underflow;
`endif

   int checks = 0;
   int errors = 0;

   logic [DB-1:0] mq[$];
   logic          ovf_m = 1'b0;
   logic          udf_m = 1'b0;

   sync_fifo #(
      .DATA_BITS (DB),
      .ADDR_BITS (AB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(mq.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(mq.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_EN
      chk({tag, ".ovf"}, 32'(overflow),  32'(ovf_m));
      chk({tag, ".udf"}, 32'(underflow), 32'(udf_m));
`endif
   endtask

   // One clock: drive, advance model by the FIFO rules, then check.
   task automatic step(input string tag, input logic w,
                       input logic [DB-1:0] d, input logic r);
      logic          ef, ff, ev;
      logic [DB-1:0] ed;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      @(posedge clk);
      ef = (mq.size() == 0);
      ff = (mq.size() == DEPTH);
      ovf_m = ovf_m | (w & ff);
      udf_m = udf_m | (r & ef);
      ev = 1'b0;
      ed = '0;
      if (r && !ef) begin
         ed = mq.pop_front();
         ev = 1'b1;
      end
      if (w && !ff)
         mq.push_back(d);
      #1;
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev));
      if (ev)
         chk({tag, ".rd_data"}, 32'(rd_data), 32'(ed));
      chk_state(tag);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] seq [4];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

      #12;
      chk_state("rst_hold");
      chk("rst_hold.rd_valid", 32'(rd_valid), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++)
         step("idle", 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 4; i++)
         step("fill", 1'b1, seq[i], 1'b0);
      chk("fill.full_now", 32'(full), 32'd1);
      step("ovf_wr", 1'b1, 8'h55, 1'b0);

      for (int i = 0; i < 4; i++)
         step("drain", 1'b0, 8'h00, 1'b1);
      chk("drain.empty_now", 32'(empty), 32'd1);
      step("udf_rd", 1'b0, 8'h00, 1'b1);

      step("pre2", 1'b1, 8'h9A, 1'b0);
      step("pre2", 1'b1, 8'h9B, 1'b0);
      for (int i = 0; i < 8; i++)
         step("simul", 1'b1, 8'hA0 + 8'(i), 1'b1);

      step("fill5", 1'b1, 8'hB0, 1'b0);
      step("fill5", 1'b1, 8'hB1, 1'b0);
      step("full_rw", 1'b1, 8'hC0, 1'b1);
      chk("full_rw.count3", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++)
         step("drain5", 1'b0, 8'h00, 1'b1);
      step("empty_rw", 1'b1, 8'hC1, 1'b1);
      chk("empty_rw.count1", 32'(count), 32'd1);

      step("pre6", 1'b1, 8'hD0, 1'b0);
      step("pre6", 1'b1, 8'hD1, 1'b0);
      step("pre6", 1'b1, 8'hD2, 1'b0);
      rd_en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      mq.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
      chk_state("async_rst");
      chk("async_rst.rd_valid", 32'(rd_valid), 32'd0);
      @(posedge clk);
      #1;
      chk_state("rst_cyc");
      chk("rst_cyc.rd_valid", 32'(rd_valid), 32'd0);
      rd_en = 1'b0;
      #2;
      reset = 1'b0;
      step("fresh", 1'b1, 8'hE0, 1'b0);
      step("fresh", 1'b1, 8'hE1, 1'b0);
      step("fresh", 1'b0, 8'h00, 1'b1);
      step("fresh", 1'b0, 8'h00, 1'b1);
      step("fresh", 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
